// File: rtl/writeback_regfile_stage.sv
// Writeback stage: one-entry holding register that retires into the 32-entry integer regfile.
// Optional retired-instruction counter is built when WB_INSTRET_EN is defined.
//
// state  | meaning
// S_IDLE | nothing held, ready for MEM
// S_HOLD | instr held with its data, retires on the next edge
// S_WAIT | load instr held, data still pending on late_valid
module writeback_regfile_stage #(
    parameter int XLEN      = 32,
    parameter int INSTRET_W = 64,
    parameter int IID_W     = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   mem_wb_valid,
    output logic                   mem_wb_ready,
    input  logic [IID_W-1:0]       mem_wb_inst_id,
    input  logic                   mem_wb_rf_wen,
    input  logic [4:0]             mem_wb_wb_addr,
    input  logic [XLEN-1:0]        mem_wb_wdata,
    input  logic                   mem_wb_wdata_ok,
    input  logic                   late_valid,
    input  logic [XLEN-1:0]        late_wdata,
    output logic [32*XLEN-1:0]     regfile,
    output logic [XLEN+6:0]        dh_wb_fw,
    output logic [INSTRET_W-1:0]   wb_instret
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HOLD = 2'd1,
        S_WAIT = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic              wen_q;
    logic              wen_nxt;
    logic [4:0]        addr_q;
    logic [4:0]        addr_nxt;
    logic [XLEN-1:0]   data_q;
    logic [XLEN-1:0]   data_nxt;
    logic              accept;
    logic              retire;
    logic              fw_valid_nxt;
    logic              fw_cf_nxt;
    logic [XLEN-1:0]   fw_wdata_nxt;
    logic [XLEN-1:0]   rf [0:31];

    // Instruction id is carried for trace only; nothing in this stage consumes it.
    logic unused_inst_id;
    assign unused_inst_id = ^mem_wb_inst_id;

    always_comb begin
        accept    = mem_wb_valid && mem_wb_ready;
        retire    = (state == S_HOLD);
        state_nxt = state;
        wen_nxt   = wen_q;
        addr_nxt  = addr_q;
        data_nxt  = data_q;
        case (state)
            S_IDLE, S_HOLD: begin
                if (accept) begin
                    state_nxt = (mem_wb_wdata_ok || !mem_wb_rf_wen) ? S_HOLD : S_WAIT;
                    wen_nxt   = mem_wb_rf_wen;
                    addr_nxt  = mem_wb_wb_addr;
                    data_nxt  = mem_wb_wdata_ok ? mem_wb_wdata : '0;
                end else if (state == S_HOLD) begin
                    state_nxt = S_IDLE;
                end
            end
            S_WAIT: begin
                if (late_valid) begin
                    state_nxt = S_HOLD;
                    data_nxt  = late_wdata;
                end
            end
            default: state_nxt = S_IDLE;
        endcase

        fw_valid_nxt = (state_nxt != S_IDLE) && wen_nxt && (addr_nxt != 5'd0);
        fw_cf_nxt    = (state_nxt == S_HOLD);
        fw_wdata_nxt = fw_cf_nxt ? data_nxt : '0;
    end

    // Outputs are registered from next-state values so they line up with the state they describe.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_IDLE;
            wen_q        <= 1'b0;
            addr_q       <= 5'd0;
            data_q       <= '0;
            mem_wb_ready <= 1'b1;
            dh_wb_fw     <= '0;
            for (int i = 0; i < 32; i++) begin
                rf[i] <= '0;
            end
        end else begin
            if (retire && wen_q && (addr_q != 5'd0)) begin
                rf[addr_q] <= data_q;
            end
            state        <= state_nxt;
            wen_q        <= wen_nxt;
            addr_q       <= addr_nxt;
            data_q       <= data_nxt;
            mem_wb_ready <= (state_nxt != S_WAIT);
            if (state_nxt == S_IDLE) begin
                dh_wb_fw <= '0;
            end else begin
                dh_wb_fw <= {fw_valid_nxt, fw_cf_nxt, addr_nxt, fw_wdata_nxt};
            end
        end
    end

    // x0 is hardwired; entry 0 of the storage array is never written.
    always_comb begin
        regfile = '0;
        for (int i = 1; i < 32; i++) begin
            regfile[i*XLEN +: XLEN] = rf[i];
        end
    end

`ifdef WB_INSTRET_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            wb_instret <= '0;
        end else if (retire) begin
            wb_instret <= wb_instret + {{(INSTRET_W-1){1'b0}}, 1'b1};
        end
    end
`else
    assign wb_instret = '0;
`endif

endmodule
